fbio_cmd_ctrl: RTL and testbench

Command sequencer between the FBIO board-to-FPGA link and the SoC AXI-Lite register space. It frames and validates 16-bit command packets from the deserialized b2f link and issues the matching single-beat AXI-Lite write or read. It returns a write-ack, read-data or error packet on the f2b link. It is the only master that host register accesses go through.

---
 rtl/fbio_cmd_ctrl_if.sv | 40 ++++
 rtl/fbio_cmd_ctrl.sv | 163 ++++++++++++++++
 tb/tb_fbio_cmd_ctrl.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fbio_cmd_ctrl_if.sv
// fbio_cmd_ctrl_if: b2f/f2b link beats, status strobes and the AXI-Lite master bus of the command sequencer.
interface fbio_cmd_ctrl_if;
    logic        in_vld;
    logic [15:0] in_data;
    logic        out_vld;
    logic [15:0] out_data;
    logic        busy;
    logic        drop;
    logic [31:0] m_awaddr;
    logic        m_awvalid;
    logic        m_awready;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_wvalid;
    logic        m_wready;
    logic [1:0]  m_bresp;
    logic        m_bvalid;
    logic        m_bready;
    logic [31:0] m_araddr;
    logic        m_arvalid;
    logic        m_arready;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rvalid;
    logic        m_rready;

    modport master (
        input  in_vld, in_data, m_awready, m_wready, m_bresp, m_bvalid,
               m_arready, m_rdata, m_rresp, m_rvalid,
        output out_vld, out_data, busy, drop, m_awaddr, m_awvalid, m_wdata,
               m_wstrb, m_wvalid, m_bready, m_araddr, m_arvalid, m_rready
    );

    modport slave (
        output in_vld, in_data, m_awready, m_wready, m_bresp, m_bvalid,
               m_arready, m_rdata, m_rresp, m_rvalid,
        input  out_vld, out_data, busy, drop, m_awaddr, m_awvalid, m_wdata,
               m_wstrb, m_wvalid, m_bready, m_araddr, m_arvalid, m_rready
    );
endinterface

// File: rtl/fbio_cmd_ctrl.sv
// fbio_cmd_ctrl: frames b2f command packets into single-beat AXI-Lite accesses and returns f2b responses.
// Defining FBIO_CMD_TIMEOUT_EN aborts AXI transactions stalled for TIMEOUT_CYCLES with resp 2'b11.
module fbio_cmd_ctrl #(
    parameter logic [15:0] ATTR_WORD      = 16'h2110,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input logic             clk,
    input logic             rst,
    fbio_cmd_ctrl_if.master io
);
    localparam logic [15:0] OP_WR = 16'h0E06;
    localparam logic [15:0] OP_RD = 16'h0014;

    typedef enum logic [3:0] {
        IDLE, RX, CHECK, AXI_WR, AXI_B, AXI_AR, AXI_R, RSP, WAIT_IDLE
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] beat_q [8];
    logic [15:0] beat_d [8];
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic [15:0] hdr_q, hdr_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  idx_q, idx_d;
    logic [1:0]  last_q, last_d;
    logic        in_vld_q, in_vld_d;
    logic        is_wr, is_rd, axi_st, tmo_hit, unused_bits;
    logic [3:0]  need, err;

    assign is_wr  = beat_q[0] == OP_WR;
    assign is_rd  = beat_q[0] == OP_RD;
    assign need   = is_wr ? 4'd7 : 4'd4;
    assign err    = !(is_wr || is_rd)        ? 4'd1 :
                    beat_q[1] != ATTR_WORD   ? 4'd2 :
                    cnt_q < need             ? 4'd3 :
                    cnt_q > need             ? 4'd4 : 4'd0;
    assign axi_st = state_q inside {AXI_WR, AXI_B, AXI_AR, AXI_R};

`ifdef FBIO_CMD_TIMEOUT_EN
    logic [15:0] tmo_q, tmo_d;

    // Runs from AXI_WR/AXI_AR entry and clears as soon as the state leaves the AXI phase.
    assign tmo_d   = axi_st ? tmo_q + 16'd1 : 16'd0;
    assign tmo_hit = axi_st && tmo_q == 16'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) tmo_q <= '0;
        else     tmo_q <= tmo_d;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        beat_d    = beat_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        hdr_d     = hdr_q;
        rdata_d   = rdata_q;
        idx_d     = idx_q;
        last_d    = last_q;
        in_vld_d  = io.in_vld;
        unique case (state_q)
            IDLE: if (io.in_vld) begin
                beat_d    = '{default: '0};
                beat_d[0] = io.in_data;
                cnt_d     = 4'd1;
                state_d   = RX;
            end
            RX: if (io.in_vld) begin
                if (cnt_q < 4'd8) beat_d[cnt_q[2:0]] = io.in_data;
                cnt_d = (cnt_q == 4'd8) ? cnt_q : cnt_q + 4'd1;
            end else begin
                state_d = CHECK;
            end
            CHECK: begin
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                hdr_d     = {8'h00, err, 4'hE};
                last_d    = 2'd0;
                state_d   = err != 4'd0 ? RSP : is_wr ? AXI_WR : AXI_AR;
            end
            AXI_WR: begin
                aw_done_d = aw_done_q || io.m_awready;
                w_done_d  = w_done_q || io.m_wready;
                if (aw_done_d && w_done_d) state_d = AXI_B;
            end
            AXI_B: if (io.m_bvalid) begin
                hdr_d   = {8'h00, 2'b00, io.m_bresp, 4'h7};
                last_d  = 2'd0;
                state_d = RSP;
            end
            AXI_AR: if (io.m_arready) state_d = AXI_R;
            AXI_R: if (io.m_rvalid) begin
                hdr_d   = {8'h00, 2'b00, io.m_rresp, 4'h5};
                rdata_d = io.m_rdata;
                last_d  = 2'd2;
                state_d = RSP;
            end
            RSP: begin
                idx_d   = (idx_q == last_q) ? 2'd0 : idx_q + 2'd1;
                state_d = (idx_q == last_q) ? WAIT_IDLE : RSP;
            end
            WAIT_IDLE: state_d = io.in_vld ? WAIT_IDLE : IDLE;
            default:   state_d = IDLE;
        endcase
        // A completion in the same cycle wins over the abort.
        if (tmo_hit && state_d != RSP) begin
            hdr_d   = {8'h00, 2'b00, 2'b11, (state_q inside {AXI_WR, AXI_B}) ? 4'h7 : 4'h5};
            rdata_d = '0;
            last_d  = (state_q inside {AXI_WR, AXI_B}) ? 2'd0 : 2'd2;
            state_d = RSP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            beat_q    <= '{default: '0};
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            hdr_q     <= '0;
            rdata_q   <= '0;
            idx_q     <= '0;
            last_q    <= '0;
            in_vld_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            beat_q    <= beat_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            hdr_q     <= hdr_d;
            rdata_q   <= rdata_d;
            idx_q     <= idx_d;
            last_q    <= last_d;
            in_vld_q  <= in_vld_d;
        end
    end

    assign io.busy      = !(state_q inside {IDLE, RX});
    assign io.drop      = io.busy && io.in_vld && !in_vld_q;
    assign io.m_awvalid = state_q == AXI_WR && !aw_done_q;
    assign io.m_wvalid  = state_q == AXI_WR && !w_done_q;
    assign io.m_bready  = state_q == AXI_B;
    assign io.m_arvalid = state_q == AXI_AR;
    assign io.m_rready  = state_q == AXI_R;
    assign io.m_awaddr  = {beat_q[3], beat_q[2]};
    assign io.m_araddr  = {beat_q[3], beat_q[2]};
    assign io.m_wdata   = {beat_q[6], beat_q[5]};
    assign io.m_wstrb   = beat_q[4][11:8];
    assign io.out_vld   = state_q == RSP;
    assign io.out_data  = !io.out_vld   ? 16'h0000 :
                          idx_q == 2'd0 ? hdr_q :
                          idx_q == 2'd1 ? rdata_q[15:0] : rdata_q[31:16];

    assign unused_bits = ^{beat_q[4][15:12], beat_q[4][7:0], beat_q[7], TIMEOUT_CYCLES};
endmodule

// File: tb/tb_fbio_cmd_ctrl.sv
// tb_fbio_cmd_ctrl: randomized packets against a packet-level reference model and a delay-configurable AXI-Lite slave.
module tb_fbio_cmd_ctrl;
    typedef logic [15:0] beats_t[$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    fbio_cmd_ctrl_if bus();

    fbio_cmd_ctrl #(.ATTR_WORD(16'h2110), .TIMEOUT_CYCLES(16)) dut (.clk(clk), .rst(rst), .io(bus));

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0, cyc = 0, drop_n = 0, viol = 0;
    int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0]  sl_bresp = 2'b00, sl_rresp = 2'b00;
    logic [31:0] sl_rdata = '0;
    int aw_w, w_w, b_w, ar_w, r_w;
    bit aw_fire, w_fire, b_fire, ar_fire, r_fire, got_aw, got_w, got_ar;
    int aw_n, w_n, ar_n;
    logic [31:0] aw_addr, w_data, ar_addr;
    logic [3:0]  w_strb;
    logic [15:0] rsp_q[$];
    int first_cyc, last_cyc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    task automatic slave_clear();
        {aw_fire, w_fire, b_fire, ar_fire, r_fire, got_aw, got_w, got_ar} = '0;
        {aw_w, w_w, b_w, ar_w, r_w} = '0;
        bus.m_awready = 0; bus.m_wready = 0; bus.m_bvalid = 0;
        bus.m_arready = 0; bus.m_rvalid = 0;
    endtask

    // AXI-Lite slave: readies/valids change 1ns after the edge; a *_fire flag means the handshake happens at the next edge.
    initial begin
        bus.in_vld = 0; bus.in_data = '0;
        bus.m_bresp = '0; bus.m_rresp = '0; bus.m_rdata = '0;
        slave_clear();
        forever begin
            @(posedge clk); #1;
            if (rst || !bus.busy) slave_clear();
            else begin
                if (aw_fire) got_aw = 1;
                if (w_fire) got_w = 1;
                if (ar_fire) got_ar = 1;
                aw_fire = 0; w_fire = 0; ar_fire = 0;
                if (b_fire) begin b_fire = 0; bus.m_bvalid = 0; got_aw = 0; got_w = 0; b_w = 0; end
                if (r_fire) begin r_fire = 0; bus.m_rvalid = 0; got_ar = 0; r_w = 0; end
                if (got_aw && got_w) begin
                    if (b_w >= b_dly) begin
                        bus.m_bvalid = 1; bus.m_bresp = sl_bresp;
                        b_fire = bus.m_bready;
                    end else b_w++;
                end
                if (got_ar) begin
                    if (r_w >= r_dly) begin
                        bus.m_rvalid = 1; bus.m_rresp = sl_rresp; bus.m_rdata = sl_rdata;
                        r_fire = bus.m_rready;
                    end else r_w++;
                end
                bus.m_awready = 0; bus.m_wready = 0; bus.m_arready = 0;
                if (bus.m_awvalid) begin
                    if (aw_w >= aw_dly) begin
                        bus.m_awready = 1; aw_fire = 1; aw_n++; aw_addr = bus.m_awaddr; aw_w = 0;
                    end else aw_w++;
                end
                if (bus.m_wvalid) begin
                    if (w_w >= w_dly) begin
                        bus.m_wready = 1; w_fire = 1; w_n++; w_data = bus.m_wdata; w_strb = bus.m_wstrb; w_w = 0;
                    end else w_w++;
                end
                if (bus.m_arvalid) begin
                    if (ar_w >= ar_dly) begin
                        bus.m_arready = 1; ar_fire = 1; ar_n++; ar_addr = bus.m_araddr; ar_w = 0;
                    end else ar_w++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (bus.out_vld) begin
            if (rsp_q.size() == 0) first_cyc = cyc;
            rsp_q.push_back(bus.out_data);
        end
        if (bus.drop) drop_n++;
        if (bus.m_bready && !(got_aw && got_w)) viol++;
    end

    function automatic beats_t mk_wr(input logic [31:0] a, input logic [31:0] d, input logic [15:0] s);
        beats_t b;
        b.push_back(16'h0E06); b.push_back(16'h2110); b.push_back(a[15:0]); b.push_back(a[31:16]);
        b.push_back(s); b.push_back(d[15:0]); b.push_back(d[31:16]);
        return b;
    endfunction

    function automatic beats_t mk_rd(input logic [31:0] a);
        beats_t b;
        b.push_back(16'h0014); b.push_back(16'h2110); b.push_back(a[15:0]); b.push_back(a[31:16]);
        return b;
    endfunction

    // Packet-level reference: missing beats read as zero; kind 0 = error, 1 = write, 2 = read.
    function automatic void model(input beats_t b, output beats_t rsp, output int kind,
                                  output logic [31:0] addr, output logic [31:0] data, output logic [3:0] strb);
        logic [15:0] g[8];
        int code, len;
        bit wr, rd;
        for (int i = 0; i < 8; i++) g[i] = (i < b.size()) ? b[i] : 16'h0000;
        wr = g[0] == 16'h0E06;
        rd = g[0] == 16'h0014;
        len = wr ? 7 : 4;
        code = (!wr && !rd) ? 1 : (g[1] != 16'h2110) ? 2 : (b.size() < len) ? 3 : (b.size() > len) ? 4 : 0;
        addr = {g[3], g[2]};
        data = {g[6], g[5]};
        strb = g[4][11:8];
        rsp = {};
        kind = 0;
        if (code != 0) rsp.push_back({8'h00, 4'(code), 4'hE});
        else if (wr) begin
            kind = 1;
            rsp.push_back({8'h00, 2'b00, sl_bresp, 4'h7});
        end else begin
            kind = 2;
            rsp.push_back({8'h00, 2'b00, sl_rresp, 4'h5});
            rsp.push_back(sl_rdata[15:0]);
            rsp.push_back(sl_rdata[31:16]);
        end
    endfunction

    task automatic clear_caps();
        aw_n = 0; w_n = 0; ar_n = 0; first_cyc = -1;
        rsp_q.delete();
    endtask

    task automatic send(input beats_t b);
        foreach (b[i]) begin
            @(posedge clk); #1;
            bus.in_vld = 1; bus.in_data = b[i]; last_cyc = cyc;
        end
        @(posedge clk); #1;
        bus.in_vld = 0; bus.in_data = '0;
    endtask

    task automatic wait_rsp(input int n);
        int t = 0;
        while (rsp_q.size() < n && t < 600) begin @(negedge clk); t++; end
        t = 0;
        while (bus.busy && t < 100) begin @(negedge clk); t++; end
        repeat (2) @(negedge clk);
        chk("idle_after", bus.busy, 0);
    endtask

    task automatic run(input string tag, input beats_t b, input int lat);
        beats_t e;
        int kind;
        logic [31:0] a, d;
        logic [3:0] s;
        model(b, e, kind, a, d, s);
        clear_caps();
        send(b);
        wait_rsp(e.size());
        chk({tag, "_nrsp"}, rsp_q.size(), e.size());
        foreach (e[i]) chk($sformatf("%s_beat%0d", tag, i), (i < rsp_q.size()) ? 32'(rsp_q[i]) : 32'hDEAD_BEEF, 32'(e[i]));
        chk({tag, "_aw_n"}, aw_n, (kind == 1) ? 1 : 0);
        chk({tag, "_w_n"}, w_n, (kind == 1) ? 1 : 0);
        chk({tag, "_ar_n"}, ar_n, (kind == 2) ? 1 : 0);
        if (kind == 1) begin
            chk({tag, "_awaddr"}, aw_addr, a);
            chk({tag, "_wdata"}, w_data, d);
            chk({tag, "_wstrb"}, 32'(w_strb), 32'(s));
        end
        if (kind == 2) chk({tag, "_araddr"}, ar_addr, a);
        if (lat >= 0) chk({tag, "_lat"}, first_cyc - last_cyc, lat);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        beats_t b;
        int k, n;
        @(negedge clk);
        chk("rst_ctl", {bus.out_vld, bus.busy, bus.drop, bus.m_awvalid, bus.m_wvalid,
                        bus.m_bready, bus.m_arvalid, bus.m_rready}, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_awaddr", bus.m_awaddr, 0);
        rst = 0;
        repeat (2) @(negedge clk);

        run("wr_dir", mk_wr(32'h7000_0000, 32'hAA55_1234, 16'h0F00), 5);
        sl_rdata = 32'h0000_5678;
        ar_dly = 3;
        run("rd_arwait", mk_rd(32'h7000_0004), 8);
        ar_dly = 0;
        run("rd_zw", mk_rd(32'h7000_0008), 5);
        b = {16'h1234, 16'h2110, 16'h0000, 16'h0000};
        run("bad_op", b, 3);
        b = {16'h0014, 16'h2111, 16'h0004, 16'h7000};
        run("bad_attr", b, 3);
        b = {16'h0014, 16'h2110, 16'h0004};
        run("short_rd", b, 3);
        b = mk_wr(32'h1, 32'h2, 16'h0300);
        b.push_back(16'h1111); b.push_back(16'h2222);
        run("long_wr", b, 3);

        // Packet arriving while the first write's B is held off.
        b_dly = 20; sl_bresp = 2'b10;
        clear_caps(); drop_n = 0;
        send(mk_wr(32'h4000_0010, 32'hCAFE_F00D, 16'h0500));
        repeat (6) @(posedge clk);
        send(mk_rd(32'h4000_0020));
        wait_rsp(1);
        chk("drop_cnt", drop_n, 1);
        chk("drop_nrsp", rsp_q.size(), 1);
        chk("drop_hdr", (rsp_q.size() > 0) ? 32'(rsp_q[0]) : 32'hDEAD_BEEF, 32'h0027);
        chk("drop_ar_n", ar_n, 0);
        chk("drop_aw_n", aw_n, 1);
        b_dly = 0; sl_bresp = 2'b00;

        // Asynchronous reset while the read address is stalled.
        ar_dly = 50;
        clear_caps();
        send(mk_rd(32'h7000_0004));
        repeat (5) @(negedge clk);
        chk("ar_pending", bus.m_arvalid, 1);
        #1 rst = 1;
        #1;
        chk("arst_ctl", {bus.out_vld, bus.busy, bus.drop, bus.m_awvalid, bus.m_wvalid,
                         bus.m_bready, bus.m_arvalid, bus.m_rready}, 0);
        chk("arst_out_data", bus.out_data, 0);
        repeat (2) @(negedge clk);
        rst = 0;
        repeat (3) @(negedge clk);
        chk("arst_no_rsp", rsp_q.size(), 0);
        ar_dly = 0; sl_rdata = 32'h1357_9BDF;
        run("rd_after_rst", mk_rd(32'h7000_0004), 5);

`ifdef FBIO_CMD_TIMEOUT_EN
        b_dly = 100000;
        clear_caps();
        send(mk_wr(32'h7000_0000, 32'h1, 16'h0F00));
        wait_rsp(1);
        chk("tmo_wr_n", rsp_q.size(), 1);
        chk("tmo_wr_hdr", (rsp_q.size() > 0) ? 32'(rsp_q[0]) : 32'hDEAD_BEEF, 32'h0037);
        chk("tmo_wr_lat", first_cyc - last_cyc, 19);
        b_dly = 0; r_dly = 100000;
        clear_caps();
        send(mk_rd(32'h7000_0000));
        wait_rsp(3);
        chk("tmo_rd_n", rsp_q.size(), 3);
        for (int i = 0; i < 3; i++)
            chk($sformatf("tmo_rd_beat%0d", i), (i < rsp_q.size()) ? 32'(rsp_q[i]) : 32'hDEAD_BEEF, (i == 0) ? 32'h0035 : 32'h0);
        r_dly = 0;
`endif

        for (int p = 0; p < 60; p++) begin
            aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
            ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
            sl_bresp = 2'($urandom); sl_rresp = 2'($urandom); sl_rdata = $urandom;
            k = $urandom_range(0, 7);
            b = (k < 4 && k[0]) ? mk_rd($urandom) : mk_wr($urandom, $urandom, 16'($urandom));
            if (k == 4) begin
                b[0] = 16'($urandom);
                if (b[0] == 16'h0E06 || b[0] == 16'h0014) b[0] = 16'hFFFF;
            end
            if (k == 5) b[1] = b[1] ^ 16'($urandom_range(1, 16'hFFFF));
            if (k == 6) begin
                n = $urandom_range(1, b.size() - 1);
                while (b.size() > n) void'(b.pop_back());
            end
            if (k == 7) begin
                n = $urandom_range(1, 3);
                repeat (n) b.push_back(16'($urandom));
            end
            run($sformatf("rnd%0d", p), b, -1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        chk("bready_order", viol, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
